// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter.
// Tie policy of the picker is selected by DMEM_ARB_RR_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LDR
  } arb_owner_t;

  localparam int ADDR_W_DEF   = 64;
  localparam int DATA_W_DEF   = 64;
  localparam int READ_LAT_DEF = 1;

  // Counter only ever holds READ_LAT-1
  function automatic int cntWidth(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  function automatic arb_owner_t otherOwner(input arb_owner_t o);
    return (o == OWN_CPU) ? OWN_LDR : OWN_CPU;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational two-way picker for the data-memory arbiter.
// DMEM_ARB_RR_EN defined: ties go to prio; undefined: CPU always wins ties.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  arb_owner_t prio,
`endif
  input  logic       cReq,
  input  logic       lReq,
  output arb_owner_t winner
);

  always_comb begin
    winner = OWN_CPU;
`ifdef DMEM_ARB_RR_EN
    if (cReq && lReq) begin
      winner = prio;
    end else if (lReq) begin
      winner = OWN_LDR;
    end
`else
    if (lReq && !cReq) begin
      winner = OWN_LDR;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between CPU and loader.
// Optional DMEM_ARB_RR_EN selects round-robin ties instead of CPU priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_done,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = cntWidth(READ_LAT);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT - 1);

  arb_state_t       state;
  arb_owner_t       owner;
  arb_owner_t       winner;
  logic             curWe;
  logic [CNT_W-1:0] latCnt;
  logic             anyReq;

  assign anyReq = c_req | l_req;

`ifdef DMEM_ARB_RR_EN
  arb_owner_t rrPtr;

  dmem_arb_pick uPick (
    .prio   (rrPtr),
    .cReq   (c_req),
    .lReq   (l_req),
    .winner (winner)
  );

  // rrPtr names the port that wins the next tie
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rrPtr <= OWN_CPU;
    end else if (state == IDLE && anyReq) begin
      rrPtr <= otherOwner(winner);
    end
  end
`else
  dmem_arb_pick uPick (
    .cReq   (c_req),
    .lReq   (l_req),
    .winner (winner)
  );
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      curWe     <= 1'b0;
      latCnt    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      c_rdata   <= '0;
      l_rdata   <= '0;
      c_done    <= 1'b0;
      l_done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (anyReq) begin
            state <= ACCESS;
            busy  <= 1'b1;
            owner <= winner;
            if (winner == OWN_CPU) begin
              curWe     <= c_we;
              mem_addr  <= c_addr;
              mem_wdata <= c_wdata;
              mem_wr    <= c_we;
            end else begin
              curWe     <= l_we;
              mem_addr  <= l_addr;
              mem_wdata <= l_wdata;
              mem_wr    <= l_we;
            end
          end
        end
        ACCESS: begin
          mem_wr <= 1'b0;
          if (curWe) begin
            state <= DONE;
            if (owner == OWN_CPU) c_done <= 1'b1;
            else                  l_done <= 1'b1;
          end else begin
            state  <= WAIT;
            latCnt <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (latCnt == '0) begin
            state <= DONE;
            if (owner == OWN_CPU) begin
              c_rdata <= mem_rdata;
              c_done  <= 1'b1;
            end else begin
              l_rdata <= mem_rdata;
              l_done  <= 1'b1;
            end
          end else begin
            latCnt <= latCnt - CNT_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          c_done <= 1'b0;
          l_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed tests for dmem_arbiter.
// A second instance is built with READ_LAT=3 for the loader latency test.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [63:0] VW = 64'hDEADBEEF;
  localparam logic [63:0] VL = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] VA = 64'hA5A5_0000_0000_00A5;
  localparam logic [63:0] VB = 64'h0000_BBBB_0000_BBBB;
  localparam logic [63:0] VC = 64'hCCCC_1111_2222_CCCC;

  logic clk = 1'b0;
  logic Reset;
  logic c_req, c_we, c_done, l_req, l_we, l_done, mem_wr, busy;
  logic [63:0] c_addr, c_wdata, c_rdata, l_addr, l_wdata, l_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic c_req3, c_we3, c_done3, l_req3, l_we3, l_done3, mem_wr3, busy3;
  logic [63:0] c_addr3, c_wdata3, c_rdata3, l_addr3, l_wdata3, l_rdata3;
  logic [63:0] mem_addr3, mem_wdata3, mem_rdata3, p0, p1;
  logic [63:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory model: latency 1 for dut, latency 3 for dut3 (read-only)
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata  <= mem[mem_addr[7:0]];
    p0         <= mem[mem_addr3[7:0]];
    p1         <= p0;
    mem_rdata3 <= p1;
  end

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .READ_LAT(1)) dut (
    .clk(clk), .Reset(Reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_done(c_done),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_done(l_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .READ_LAT(3)) dut3 (
    .clk(clk), .Reset(Reset),
    .c_req(c_req3), .c_we(c_we3), .c_addr(c_addr3), .c_wdata(c_wdata3),
    .c_rdata(c_rdata3), .c_done(c_done3),
    .l_req(l_req3), .l_we(l_we3), .l_addr(l_addr3), .l_wdata(l_wdata3),
    .l_rdata(l_rdata3), .l_done(l_done3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wr(mem_wr3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    c_req3 = 0; c_we3 = 0; c_addr3 = 0; c_wdata3 = 0;
    l_req3 = 0; l_we3 = 0; l_addr3 = 0; l_wdata3 = 0;
    cyc(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL rst_memwr got=%0h exp=0", mem_wr); end
    checks++; if ({c_done, l_done} !== 2'b00) begin failures++; $display("FAIL rst_done got=%b exp=00", {c_done, l_done}); end
    checks++; if (c_rdata !== 64'h0) begin failures++; $display("FAIL rst_crdata got=%h exp=0", c_rdata); end
    checks++; if (l_rdata !== 64'h0) begin failures++; $display("FAIL rst_lrdata got=%h exp=0", l_rdata); end
    checks++; if (mem_addr !== 64'h0) begin failures++; $display("FAIL rst_memaddr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 64'h0) begin failures++; $display("FAIL rst_memwdata got=%h exp=0", mem_wdata); end
    Reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_cpu_write;
    c_req = 1; c_we = 1; c_addr = 64'h10; c_wdata = VW;
    cyc(1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy1 got=%0h exp=1", busy); end
    checks++; if (mem_wr !== 1'b1) begin failures++; $display("FAIL wr_memwr1 got=%0h exp=1", mem_wr); end
    checks++; if (mem_addr !== 64'h10) begin failures++; $display("FAIL wr_addr got=%h exp=10", mem_addr); end
    checks++; if (mem_wdata !== VW) begin failures++; $display("FAIL wr_wdata got=%h exp=%h", mem_wdata, VW); end
    checks++; if (c_done !== 1'b0) begin failures++; $display("FAIL wr_done_early got=%0h exp=0", c_done); end
    cyc(1);
    checks++; if (c_done !== 1'b1) begin failures++; $display("FAIL wr_done got=%0h exp=1", c_done); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL wr_memwr2 got=%0h exp=0", mem_wr); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy2 got=%0h exp=1", busy); end
    c_req = 0;
    cyc(1);
    checks++; if ({busy, c_done} !== 2'b00) begin failures++; $display("FAIL wr_idle got=%b exp=00", {busy, c_done}); end
    checks++; if (mem_addr !== 64'h10) begin failures++; $display("FAIL wr_addr_hold got=%h exp=10", mem_addr); end
  endtask

  task automatic test_cpu_read;
    c_req = 1; c_we = 0; c_addr = 64'h10;
    cyc(1);
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL rd_memwr got=%0h exp=0", mem_wr); end
    cyc(1);
    checks++; if (c_done !== 1'b0) begin failures++; $display("FAIL rd_done_early got=%0h exp=0", c_done); end
    cyc(1);
    checks++; if (c_done !== 1'b1) begin failures++; $display("FAIL rd_done got=%0h exp=1", c_done); end
    checks++; if (c_rdata !== VW) begin failures++; $display("FAIL rd_data got=%h exp=%h", c_rdata, VW); end
    c_req = 0;
    cyc(1);
    checks++; if (c_done !== 1'b0) begin failures++; $display("FAIL rd_done_pulse got=%0h exp=0", c_done); end
    checks++; if (c_rdata !== VW) begin failures++; $display("FAIL rd_hold got=%h exp=%h", c_rdata, VW); end
    checks++; if (l_rdata !== 64'h0) begin failures++; $display("FAIL rd_lrdata got=%h exp=0", l_rdata); end
  endtask

  task automatic test_loader_write;
    l_req = 1; l_we = 1; l_addr = 64'h18; l_wdata = VL;
    cyc(1);
    checks++; if (mem_wr !== 1'b1 || mem_addr !== 64'h18) begin failures++; $display("FAIL lw_mem got=%0h/%h exp=1/18", mem_wr, mem_addr); end
    cyc(1);
    checks++; if ({l_done, c_done} !== 2'b10) begin failures++; $display("FAIL lw_done got=%b exp=10", {l_done, c_done}); end
    l_req = 0;
    cyc(1);
  endtask

  task automatic test_tie;
    c_req = 1; c_we = 0; c_addr = 64'h10;
    l_req = 1; l_we = 0; l_addr = 64'h18;
    cyc(1);
    checks++; if (mem_addr !== 64'h10) begin failures++; $display("FAIL tie_first got=%h exp=10", mem_addr); end
    cyc(2);
    checks++; if ({c_done, l_done} !== 2'b10) begin failures++; $display("FAIL tie_cdone got=%b exp=10", {c_done, l_done}); end
    c_req = 0;
    cyc(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tie_idle got=%0h exp=0", busy); end
    cyc(1);
    checks++; if (mem_addr !== 64'h18 || busy !== 1'b1) begin failures++; $display("FAIL tie_second got=%h/%0h exp=18/1", mem_addr, busy); end
    cyc(2);
    checks++; if (l_done !== 1'b1) begin failures++; $display("FAIL tie_ldone got=%0h exp=1", l_done); end
    checks++; if (l_rdata !== VL) begin failures++; $display("FAIL tie_ldata got=%h exp=%h", l_rdata, VL); end
    checks++; if (c_rdata !== VW) begin failures++; $display("FAIL tie_cdata got=%h exp=%h", c_rdata, VW); end
    l_req = 0;
    cyc(1);
  endtask

  task automatic test_held_loader;
    c_req = 1; c_we = 1; c_addr = 64'h20; c_wdata = VA;
    cyc(1);
    l_req = 1; l_we = 1; l_addr = 64'h28; l_wdata = VB;
    checks++; if (mem_wr !== 1'b1 || mem_addr !== 64'h20) begin failures++; $display("FAIL hold_cwr got=%0h/%h exp=1/20", mem_wr, mem_addr); end
    cyc(1);
    checks++; if ({c_done, mem_wr} !== 2'b10) begin failures++; $display("FAIL hold_cdone got=%b exp=10", {c_done, mem_wr}); end
    c_req = 0;
    cyc(1);
    checks++; if ({busy, mem_wr} !== 2'b00) begin failures++; $display("FAIL hold_idle got=%b exp=00", {busy, mem_wr}); end
    cyc(1);
    checks++; if (mem_wr !== 1'b1 || mem_addr !== 64'h28 || mem_wdata !== VB) begin failures++; $display("FAIL hold_lwr got=%0h/%h/%h exp=1/28/%h", mem_wr, mem_addr, mem_wdata, VB); end
    cyc(1);
    checks++; if ({l_done, mem_wr} !== 2'b10) begin failures++; $display("FAIL hold_ldone got=%b exp=10", {l_done, mem_wr}); end
    l_req = 0;
    cyc(1);
  endtask

  task automatic test_second_tie;
    logic [63:0] firstAddr, secondAddr, firstData, secondData;
    firstAddr  = RR_EN ? 64'h28 : 64'h30;
    secondAddr = RR_EN ? 64'h30 : 64'h28;
    firstData  = RR_EN ? VB : VC;
    secondData = RR_EN ? VC : VB;
    c_req = 1; c_we = 1; c_addr = 64'h30; c_wdata = VC;
    cyc(2);
    c_req = 0;
    cyc(1);
    c_req = 1; c_we = 0; c_addr = 64'h30;
    l_req = 1; l_we = 0; l_addr = 64'h28;
    cyc(1);
    checks++; if (mem_addr !== firstAddr) begin failures++; $display("FAIL tie2_first got=%h exp=%h", mem_addr, firstAddr); end
    cyc(2);
    checks++; if ({c_done, l_done} !== {!RR_EN, RR_EN}) begin failures++; $display("FAIL tie2_done1 got=%b exp=%b", {c_done, l_done}, {!RR_EN, RR_EN}); end
    checks++; if ((RR_EN ? l_rdata : c_rdata) !== firstData) begin failures++; $display("FAIL tie2_data1 got=%h exp=%h", RR_EN ? l_rdata : c_rdata, firstData); end
    if (RR_EN) l_req = 0; else c_req = 0;
    cyc(2);
    checks++; if (mem_addr !== secondAddr) begin failures++; $display("FAIL tie2_second got=%h exp=%h", mem_addr, secondAddr); end
    cyc(2);
    checks++; if ({c_done, l_done} !== {RR_EN, !RR_EN}) begin failures++; $display("FAIL tie2_done2 got=%b exp=%b", {c_done, l_done}, {RR_EN, !RR_EN}); end
    checks++; if ((RR_EN ? c_rdata : l_rdata) !== secondData) begin failures++; $display("FAIL tie2_data2 got=%h exp=%h", RR_EN ? c_rdata : l_rdata, secondData); end
    c_req = 0; l_req = 0;
    cyc(1);
  endtask

  task automatic test_reset_mid;
    c_req = 1; c_we = 1; c_addr = 64'h40; c_wdata = VA;
    cyc(1);
    Reset = 1'b1;
    #1;
    checks++; if ({mem_wr, busy} !== 2'b00) begin failures++; $display("FAIL rstacc_wr got=%b exp=00", {mem_wr, busy}); end
    c_req = 0;
    cyc(1);
    Reset = 1'b0;
    checks++; if (c_done !== 1'b0) begin failures++; $display("FAIL rstacc_done got=%0h exp=0", c_done); end
    cyc(1);
    c_req = 1; c_we = 0; c_addr = 64'h10;
    cyc(2);
    checks++; if (busy !== 1'b1 || c_done !== 1'b0) begin failures++; $display("FAIL rstwait_pre got=%0h/%0h exp=1/0", busy, c_done); end
    Reset = 1'b1;
    #1;
    checks++; if ({mem_wr, busy, c_done} !== 3'b000) begin failures++; $display("FAIL rstwait_out got=%b exp=000", {mem_wr, busy, c_done}); end
    c_req = 0;
    cyc(1);
    Reset = 1'b0;
    checks++; if (c_done !== 1'b0 || c_rdata !== 64'h0) begin failures++; $display("FAIL rstwait_done got=%0h/%h exp=0/0", c_done, c_rdata); end
    cyc(1);
    c_req = 1; c_we = 0; c_addr = 64'h18;
    cyc(3);
    checks++; if (c_done !== 1'b1 || c_rdata !== VL) begin failures++; $display("FAIL rstwait_next got=%0h/%h exp=1/%h", c_done, c_rdata, VL); end
    c_req = 0;
    cyc(1);
  endtask

  task automatic test_lat3;
    l_req3 = 1; l_we3 = 0; l_addr3 = 64'h18;
    cyc(4);
    checks++; if (l_done3 !== 1'b0) begin failures++; $display("FAIL lat3_early got=%0h exp=0", l_done3); end
    checks++; if (mem_rdata3 !== VL) begin failures++; $display("FAIL lat3_memdata got=%h exp=%h", mem_rdata3, VL); end
    cyc(1);
    checks++; if (l_done3 !== 1'b1) begin failures++; $display("FAIL lat3_done got=%0h exp=1", l_done3); end
    checks++; if (l_rdata3 !== VL) begin failures++; $display("FAIL lat3_data got=%h exp=%h", l_rdata3, VL); end
    checks++; if (c_rdata3 !== 64'h0) begin failures++; $display("FAIL lat3_crdata got=%h exp=0", c_rdata3); end
    l_req3 = 0;
    cyc(1);
    checks++; if ({l_done3, busy3} !== 2'b00) begin failures++; $display("FAIL lat3_idle got=%b exp=00", {l_done3, busy3}); end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_loader_write();
    test_tie();
    test_held_loader();
    test_second_tie();
    test_reset_mid();
    test_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
